// File: rtl/cpu_defs.sv
// Shared opcode constants, sequencer state encoding and IR field positions.
// Used by the sequencer, the ALU and the register select/encode logic.
package cpu_defs;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b01001;
    localparam opcode_t OP_OR   = 5'b01010;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT,
        ST_FAULT
    } state_t;

    function automatic opcode_t get_opcode(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath signal bundle: IR/MemDone/Stop in, control strobes and status out.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
    import cpu_defs::*;

    logic [31:0] IR;
    logic        MemDone;
    logic        Stop;

    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc;
    logic        Rin, Rout;
    opcode_t     ALUop;
    logic        Run, Fault;

    modport master (
        input  IR, MemDone, Stop,
        output PCout, Zlowout, Zhighout, MDRout,
               MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALUop, Run, Fault
    );

    modport slave (
        output IR, MemDone, Stop,
        input  PCout, Zlowout, Zhighout, MDRout,
               MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALUop, Run, Fault
    );

endinterface

// File: rtl/control_sequencer_opcode_class.sv
// Combinational opcode classifier; zero latency, no handshake.
// is_binary covers MUL/DIV too, since they share T3/T4 with the two-operand ALU ops.
module opcode_class
    import cpu_defs::*;
(
    input  opcode_t opcode,
    output logic    is_binary,
    output logic    is_unary,
    output logic    is_muldiv,
    output logic    is_nop,
    output logic    is_halt,
    output logic    is_illegal
);

    always_comb begin
        is_binary  = 1'b0;
        is_unary   = 1'b0;
        is_muldiv  = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_binary = 1'b1;
            OP_MUL, OP_DIV: begin
                is_binary = 1'b1;
                is_muldiv = 1'b1;
            end
            OP_NEG, OP_NOT: is_unary   = 1'b1;
            OP_NOP:         is_nop     = 1'b1;
            OP_HALT:        is_halt    = 1'b1;
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: Moore strobes from (state, opcode); one state per clock.
// Stalls in T1 until MemDone; Stop only honoured on the edge that would re-enter T0.
module control_sequencer
    import cpu_defs::*;
(
    input  logic                 Clock,
    input  logic                 Clear,
    control_sequencer_if.master  bus
);

    state_t  state, next_state;
    state_t  end_state;
    opcode_t opcode;
    logic    is_binary, is_unary, is_muldiv, is_nop, is_halt, is_illegal;

    assign opcode    = get_opcode(bus.IR);
    assign end_state = bus.Stop ? ST_HALT : ST_T0;

    opcode_class u_opcode_class (
        .opcode     (opcode),
        .is_binary  (is_binary),
        .is_unary   (is_unary),
        .is_muldiv  (is_muldiv),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge Clock) begin
        if (!Clear) state <= ST_RESET;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.ALUop    = '0;
        bus.Run      = 1'b0;
        bus.Fault    = 1'b0;

        case (state)
            ST_RESET: next_state = ST_T0;
            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                // PCin held while stalled: Z still carries PC+1, so repeated loads are harmless
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.MemDone) next_state = ST_T2;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                next_state = ST_T3;
            end
            ST_T3: begin
                if (is_illegal) begin
                    next_state = ST_FAULT;
                end else if (is_binary) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    next_state = ST_T4;
                end else if (is_unary) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALUop  = opcode;
                    bus.Zin    = 1'b1;
                    next_state = ST_T4;
                end else if (is_nop) begin
                    next_state = end_state;
                end else begin
                    next_state = ST_HALT;
                end
            end
            ST_T4: begin
                if (is_binary) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALUop  = opcode;
                    bus.Zin    = 1'b1;
                    next_state = ST_T5;
                end else if (is_unary) begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    next_state  = end_state;
                end else begin
                    // IR changed under an executing instruction
                    next_state = ST_FAULT;
                end
            end
            ST_T5: begin
                if (is_muldiv) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    next_state  = ST_T6;
                end else if (is_binary) begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    next_state  = end_state;
                end else begin
                    next_state = ST_FAULT;
                end
            end
            ST_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                next_state   = end_state;
            end
            ST_HALT:  next_state = ST_HALT;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_RESET;
        endcase

        bus.Run   = (state inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6});
        bus.Fault = (state == ST_FAULT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: per-instruction strobe traces built from the
// instruction-class tables, queued per cycle and compared by a negedge monitor.
module tb_control_sequencer;

    typedef logic [25:0] vec_t;
    typedef struct {
        vec_t  v;
        string tag;
    } exp_t;

    localparam vec_t M_PCOUT  = 26'd1 << 0;
    localparam vec_t M_ZLOW   = 26'd1 << 1;
    localparam vec_t M_ZHIGH  = 26'd1 << 2;
    localparam vec_t M_MDROUT = 26'd1 << 3;
    localparam vec_t M_MARIN  = 26'd1 << 4;
    localparam vec_t M_PCIN   = 26'd1 << 5;
    localparam vec_t M_MDRIN  = 26'd1 << 6;
    localparam vec_t M_IRIN   = 26'd1 << 7;
    localparam vec_t M_YIN    = 26'd1 << 8;
    localparam vec_t M_ZIN    = 26'd1 << 9;
    localparam vec_t M_HIIN   = 26'd1 << 10;
    localparam vec_t M_LOIN   = 26'd1 << 11;
    localparam vec_t M_INCPC  = 26'd1 << 12;
    localparam vec_t M_READ   = 26'd1 << 13;
    localparam vec_t M_GRA    = 26'd1 << 14;
    localparam vec_t M_GRB    = 26'd1 << 15;
    localparam vec_t M_GRC    = 26'd1 << 16;
    localparam vec_t M_RIN    = 26'd1 << 17;
    localparam vec_t M_ROUT   = 26'd1 << 18;
    localparam vec_t M_RUN    = 26'd1 << 19;
    localparam vec_t M_FAULT  = 26'd1 << 20;

    logic Clock;
    logic Clear;
    int   tests;
    int   fails;
    exp_t exp_q[$];
    vec_t act;

    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign act = {bus.ALUop, bus.Fault, bus.Run, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                  bus.Read, bus.IncPC, bus.LOin, bus.HIin, bus.Zin, bus.Yin, bus.IRin,
                  bus.MDRin, bus.PCin, bus.MARin, bus.MDRout, bus.Zhighout, bus.Zlowout,
                  bus.PCout};

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s: outputs actual=%h required=%h", e.tag, act, e.v);
            end
        end
    end

    function automatic vec_t alu(input logic [4:0] op);
        return vec_t'(op) << 21;
    endfunction

    // 0 ADD/SUB/AND/OR, 1 MUL/DIV, 2 NEG/NOT, 3 NOP, 4 HALT, 5 illegal
    function automatic int kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010: return 0;
            5'b01111, 5'b10000:                     return 1;
            5'b10001, 5'b10010:                     return 2;
            5'b11010:                               return 3;
            5'b11011:                               return 4;
            default:                                return 5;
        endcase
    endfunction

    // Called just after a rising edge: records what this cycle must show, drives inputs for the next edge
    task automatic cyc(input vec_t e, input string tag, input logic clr, input logic md,
                       input logic stp, input logic [31:0] ir);
        exp_t x;
        x.v   = e;
        x.tag = tag;
        exp_q.push_back(x);
        Clear       = clr;
        bus.MemDone = md;
        bus.Stop    = stp;
        bus.IR      = ir;
        @(posedge Clock);
        #1;
    endtask

    // ending: 0 = back in T0, 1 = HALT, 2 = FAULT
    task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at,
                             input int stop_mode, output int ending);
        vec_t        st[$];
        string       nm[$];
        logic [4:0]  op;
        int          k;
        logic        clr, md, stp, last_stop;
        logic [31:0] irv;
        bit          aborted;
        op = ir[31:27];
        k  = kind(op);
        st.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN); nm.push_back("T0");
        for (int w = 0; w <= waits; w++) begin
            st.push_back(M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN); nm.push_back("T1");
        end
        st.push_back(M_RUN | M_MDROUT | M_IRIN); nm.push_back("T2");
        case (k)
            0, 1: begin
                st.push_back(M_RUN | M_GRB | M_ROUT | M_YIN); nm.push_back("T3");
                st.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(op)); nm.push_back("T4");
                if (k == 0) begin
                    st.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN); nm.push_back("T5");
                end else begin
                    st.push_back(M_RUN | M_ZLOW | M_LOIN); nm.push_back("T5");
                    st.push_back(M_RUN | M_ZHIGH | M_HIIN); nm.push_back("T6");
                end
            end
            2: begin
                st.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | alu(op)); nm.push_back("T3");
                st.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN); nm.push_back("T4");
            end
            default: begin
                st.push_back(M_RUN); nm.push_back("T3");
            end
        endcase

        aborted   = 1'b0;
        last_stop = 1'b0;
        for (int i = 0; i < st.size() && !aborted; i++) begin
            clr = (i == abort_at) ? 1'b0 : 1'b1;
            if (i >= 1 && i <= waits)  md = 1'b0;
            else if (i == waits + 1)   md = 1'b1;
            else                       md = 1'($urandom);
            case (stop_mode)
                0:       stp = 1'b0;
                1:       stp = ($urandom % 6 == 0);
                default: stp = (i >= waits + 3);
            endcase
            irv       = (i >= waits + 2) ? ir : $urandom;
            last_stop = stp;
            cyc(st[i], $sformatf("%s ir=%h", nm[i], ir), clr, md, stp, irv);
            if (!clr) aborted = 1'b1;
        end

        if (aborted) begin
            cyc('0, "reset after abort", 1'b1, 1'($urandom), 1'($urandom), $urandom);
            ending = 0;
        end else if (k == 4) ending = 1;
        else if (k == 5)     ending = 2;
        else                 ending = last_stop ? 1 : 0;
    endtask

    // Parked in HALT/FAULT: must stay put whatever arrives, until Clear drops
    task automatic park(input int ending, input int n);
        vec_t idle_v;
        if (ending == 0) return;
        idle_v = (ending == 2) ? M_FAULT : '0;
        for (int i = 0; i < n; i++)
            cyc(idle_v, (ending == 2) ? "fault idle" : "halt idle", 1'b1,
                1'($urandom), 1'($urandom), $urandom);
        cyc(idle_v, "parked with clear low", 1'b0, 1'($urandom), 1'($urandom), $urandom);
        cyc('0, "reset state", 1'b1, 1'($urandom), 1'($urandom), $urandom);
    endtask

    initial begin
        logic [4:0] legal_ops [9];
        int         ending;
        logic [4:0] op;
        int         r;
        legal_ops = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01111,
                      5'b10000, 5'b10001, 5'b10010, 5'b11010};
        tests       = 0;
        fails       = 0;
        Clear       = 1'b0;
        bus.IR      = '0;
        bus.MemDone = 1'b1;
        bus.Stop    = 1'b0;
        @(posedge Clock);
        #1;
        cyc('0, "reset cycle 1", 1'b0, 1'b1, 1'b0, 32'h0);
        cyc('0, "reset cycle 2", 1'b1, 1'b1, 1'b0, 32'h0);

        run_instr(32'h4A920000, 0, -1, 0, ending); park(ending, 3);
        run_instr(32'h78188000, 0, -1, 0, ending); park(ending, 3);
        run_instr(32'h18918000, 3, -1, 0, ending); park(ending, 3);
        run_instr(32'hD8000000, 0, -1, 0, ending); park(ending, 10);
        run_instr(32'hF8000000, 0, -1, 1, ending); park(ending, 6);
        run_instr(32'h1A920000, 1, -1, 2, ending); park(ending, 4);
        run_instr(32'h82918000, 0, 4, 0, ending);  park(ending, 3);
        run_instr(32'h52918000, 0, -1, 2, ending); park(ending, 2);

        for (int n = 0; n < 150; n++) begin
            r = $urandom % 10;
            if (r < 8)       op = legal_ops[$urandom % 9];
            else if (r == 8) op = 5'b11011;
            else             op = 5'($urandom);
            run_instr({op, 27'($urandom)}, $urandom % 3,
                      ($urandom % 8 == 0) ? int'($urandom % 8) : -1, 1, ending);
            park(ending, 1 + $urandom % 3);
        end

        @(negedge Clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: pending actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
